// File: rtl/vga_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Shared definitions for the VGA scan-out slice: colour-mode
//             encodings, default 640x480@60 timing, and the RGB332 expander.
//  Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

   // Colour-mode encodings as seen on the mode input.
   typedef enum logic [1:0] {
      MODE_GREY   = 2'b00,
      MODE_RGB332 = 2'b01,
      MODE_BARS   = 2'b10,
      MODE_BLACK  = 2'b11
   } mode_e;

   // One output pixel, 8 bits per channel.
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Default 640x480 timing (pixel units / line units).
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // Default memory-side configuration.
   localparam int DEF_ADDR_W   = 19;
   localparam int DEF_MEM_LAT  = 1;
   localparam int DEF_SCALE_SH = 0;

   // Expand an RGB332 byte to 8 bits per channel by repeating the
   // field bits, so full-scale codes map to 0xFF and zero to 0x00.
   function automatic rgb_t rgb332_expand(input logic [7:0] d);
      rgb_t c;
      c.r = {d[7:5], d[7:5], d[7:6]};
      c.g = {d[4:2], d[4:2], d[4:3]};
      c.b = {d[1:0], d[1:0], d[1:0], d[1:0]};
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Horizontal/vertical pixel counters and the raw (undelayed)
//             region signals derived from them.
//  Ports    : clk, reset     - clock, asynchronous active-high reset
//             pix_en         - pixel-rate strobe; counters advance only on it
//             h, v           - registered pixel / line counters
//             visible        - h < H_ACTIVE && v < V_ACTIVE
//             hs_n, vs_n     - raw active-low syncs
//             line_end       - h is on the last pixel of the line
//             frame_end      - last pixel of the last line
//             frame_start    - pix_en strobe at h=0, v=0
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int H_W      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
   parameter int V_W      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
)(
   input  logic           clk,
   input  logic           reset,
   input  logic           pix_en,
   output logic [H_W-1:0] h,
   output logic [V_W-1:0] v,
   output logic           visible,
   output logic           hs_n,
   output logic           vs_n,
   output logic           line_end,
   output logic           frame_end,
   output logic           frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [31:0] c_h_act      = 32'(H_ACTIVE);
   localparam logic [31:0] c_h_sync_beg = 32'(H_ACTIVE + H_FP);
   localparam logic [31:0] c_h_sync_end = 32'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [31:0] c_h_last     = 32'(H_TOTAL - 1);
   localparam logic [31:0] c_v_act      = 32'(V_ACTIVE);
   localparam logic [31:0] c_v_sync_beg = 32'(V_ACTIVE + V_FP);
   localparam logic [31:0] c_v_sync_end = 32'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [31:0] c_v_last     = 32'(V_TOTAL - 1);

   logic [H_W-1:0] r_h;
   logic [V_W-1:0] r_v;
   logic [31:0]    w_h32;
   logic [31:0]    w_v32;
   logic           w_line_end;
   logic           w_frame_end;

   // Region compares are done at 32 bits so a sync end that lands exactly
   // on the counter's power-of-two limit cannot overflow.
   assign w_h32       = 32'(r_h);
   assign w_v32       = 32'(r_v);
   assign w_line_end  = (w_h32 == c_h_last);
   assign w_frame_end = w_line_end && (w_v32 == c_v_last);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_h <= '0;
         r_v <= '0;
      end else if (pix_en) begin
         if (w_line_end) begin
            r_h <= '0;
            r_v <= w_frame_end ? '0 : r_v + V_W'(1);
         end else begin
            r_h <= r_h + H_W'(1);
         end
      end
   end

   assign h           = r_h;
   assign v           = r_v;
   assign visible     = (w_h32 < c_h_act) && (w_v32 < c_v_act);
   assign hs_n        = !((w_h32 >= c_h_sync_beg) && (w_h32 < c_h_sync_end));
   assign vs_n        = !((w_v32 >= c_v_sync_beg) && (w_v32 < c_v_sync_end));
   assign line_end    = w_line_end;
   assign frame_end   = w_frame_end;
   assign frame_start = pix_en && (r_h == '0) && (r_v == '0);

endmodule
`default_nettype wire

// File: rtl/vga_pixel_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vga_pixel_pipe
//  Purpose  : VGA scan-out engine. Generates timing, issues frame-buffer
//             reads (with optional pixel replication), delays the region
//             signals to line up with memory read data, and converts the
//             returned byte to 8-bit R/G/B in the selected colour mode.
//  Ports    : clk, reset         - clock, asynchronous active-high reset
//             pix_en             - pixel-rate strobe
//             mode[1:0]          - colour mode, sampled at frame start
//             mem_addr, mem_rd   - frame-buffer read request
//             mem_data[7:0]      - read data, MEM_LAT strobes after request
//             vga_hs, vga_vs     - active-low syncs (aligned with colour)
//             vga_blank          - 1 = visible pixel
//             r_out/g_out/b_out  - colour to the DAC
//             frame_start        - undelayed pulse at h=0, v=0
//  Revision : 1.0  initial release
// ============================================================================
module vga_pixel_pipe
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int MEM_LAT  = DEF_MEM_LAT,
   parameter int SCALE_SH = DEF_SCALE_SH
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_en,
   input  logic [1:0]        mode,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_data,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_blank,
   output logic [7:0]        r_out,
   output logic [7:0]        g_out,
   output logic [7:0]        b_out,
   output logic              frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_W     = $clog2(H_TOTAL);
   localparam int V_W     = $clog2(V_TOTAL);
   // Pipe word: {visible, hs_n, vs_n, h}
   localparam int PW      = H_W + 3;

   localparam logic [ADDR_W-1:0] c_line_step = ADDR_W'(H_ACTIVE >> SCALE_SH);
   localparam logic [V_W-1:0]    c_v_mask    = V_W'((1 << SCALE_SH) - 1);
   localparam logic [31:0]       c_v_act     = 32'(V_ACTIVE);
   localparam logic [H_W+2:0]    c_bar_div   = (H_W+3)'(H_ACTIVE);
   // Flushed pipe entry: not visible, syncs inactive (high).
   localparam logic [PW-1:0]     c_flush     = {1'b0, 1'b1, 1'b1, {H_W{1'b0}}};

   // ------------------------------------------------------------------
   // Timing
   // ------------------------------------------------------------------
   logic [H_W-1:0] w_h;
   logic [V_W-1:0] w_v;
   logic           w_visible;
   logic           w_hs_n;
   logic           w_vs_n;
   logic           w_line_end;
   logic           w_frame_end;
   logic           w_frame_start;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .H_W      (H_W),
      .V_W      (V_W)
   ) u_timing (
      .clk         (clk),
      .reset       (reset),
      .pix_en      (pix_en),
      .h           (w_h),
      .v           (w_v),
      .visible     (w_visible),
      .hs_n        (w_hs_n),
      .vs_n        (w_vs_n),
      .line_end    (w_line_end),
      .frame_end   (w_frame_end),
      .frame_start (w_frame_start)
   );

   // ------------------------------------------------------------------
   // Address generator
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] r_line_base;
   logic [ADDR_W-1:0] r_addr_hold;
   logic [ADDR_W-1:0] w_addr_live;
   logic              w_v_active;
   logic              w_last_rep_line;

   assign w_addr_live     = r_line_base + ADDR_W'(w_h >> SCALE_SH);
   assign w_v_active      = (32'(w_v) < c_v_act);
   // With replication each source line is shown 2^SCALE_SH times; the base
   // only moves on after the last repeat of the line.
   assign w_last_rep_line = ((w_v & c_v_mask) == c_v_mask);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_line_base <= '0;
         r_addr_hold <= '0;
      end else if (pix_en) begin
         if (w_visible) begin
            r_addr_hold <= w_addr_live;
         end
         if (w_frame_end) begin
            r_line_base <= '0;
         end else if (w_line_end && w_v_active && w_last_rep_line) begin
            r_line_base <= r_line_base + c_line_step;
         end
      end
   end

   // Outside the visible area the address parks on the last one issued.
   assign mem_addr = w_visible ? w_addr_live : r_addr_hold;
   // The counters sit at the visible origin during reset, so the request
   // and frame pulse are masked by reset to keep them low while it is held.
   assign mem_rd      = w_visible && !reset;
   assign frame_start = w_frame_start && !reset;

   // ------------------------------------------------------------------
   // Mode latch: a new mode only takes effect from a frame boundary.
   // ------------------------------------------------------------------
   mode_e r_mode_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode_q <= MODE_GREY;
      end else if (w_frame_start) begin
         r_mode_q <= mode_e'(mode);
      end
   end

   // ------------------------------------------------------------------
   // Alignment pipe: MEM_LAT stages so the region signals arrive at the
   // output stage together with the data read for the same pixel.
   // ------------------------------------------------------------------
   logic [PW-1:0] r_pipe [MEM_LAT];
   logic [PW-1:0] w_pipe_in;
   logic [PW-1:0] w_tap;
   logic          w_tap_vis;
   logic          w_tap_hs_n;
   logic          w_tap_vs_n;
   logic [H_W-1:0] w_tap_h;

   assign w_pipe_in = {w_visible, w_hs_n, w_vs_n, w_h};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MEM_LAT; i++) begin
            r_pipe[i] <= c_flush;
         end
      end else if (pix_en) begin
         r_pipe[0] <= w_pipe_in;
         for (int i = 1; i < MEM_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign w_tap      = r_pipe[MEM_LAT-1];
   assign w_tap_vis  = w_tap[PW-1];
   assign w_tap_hs_n = w_tap[PW-2];
   assign w_tap_vs_n = w_tap[PW-3];
   assign w_tap_h    = w_tap[H_W-1:0];

   // ------------------------------------------------------------------
   // Colour stage
   // ------------------------------------------------------------------
   rgb_t       w_rgb;
   rgb_t       w_rgb332;
   logic [2:0] w_band;

   assign w_rgb332 = rgb332_expand(mem_data);
   // Band index h*8/H_ACTIVE; only meaningful while h is visible.
   assign w_band   = 3'({w_tap_h, 3'b000} / c_bar_div);

   always_comb begin
      w_rgb = '0;
      case (r_mode_q)
         MODE_GREY:   w_rgb = '{r: mem_data, g: mem_data, b: mem_data};
         MODE_RGB332: w_rgb = w_rgb332;
         MODE_BARS:   w_rgb = '{r: {8{w_band[2]}}, g: {8{w_band[1]}}, b: {8{w_band[0]}}};
         default:     w_rgb = '0;
      endcase
      if (!w_tap_vis) begin
         w_rgb = '0;
      end
   end

   logic r_vga_hs;
   logic r_vga_vs;
   logic r_vga_blank;
   rgb_t r_rgb;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vga_hs    <= 1'b1;
         r_vga_vs    <= 1'b1;
         r_vga_blank <= 1'b0;
         r_rgb       <= '0;
      end else if (pix_en) begin
         r_vga_hs    <= w_tap_hs_n;
         r_vga_vs    <= w_tap_vs_n;
         r_vga_blank <= w_tap_vis;
         r_rgb       <= w_rgb;
      end
   end

   assign vga_hs    = r_vga_hs;
   assign vga_vs    = r_vga_vs;
   assign vga_blank = r_vga_blank;
   assign r_out     = r_rgb.r;
   assign g_out     = r_rgb.g;
   assign b_out     = r_rgb.b;

endmodule
`default_nettype wire

// File: doc/vga_pixel_pipe.md
# vga_pixel_pipe

Parametrised VGA scan-out engine that generates sync and blank timing, issues frame-buffer read addresses, and realigns returned pixel data with the delayed sync signals. It produces 8-bit R/G/B for the DAC. It sits between the frame-buffer memory (byte-wide, read-only port) and the board VGA DAC. It supersedes the fixed 640x480 greyscale front-end with four behaviours:
- configurable timing
- pixel replication (upscaling)
- memory-latency compensation
- selectable colour modes

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (pixels)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (lines)
- ADDR_W, 19, frame-buffer address width
- MEM_LAT, 1, frame-buffer read latency in pixel cycles (1..4)
- SCALE_SH, 0, log2 pixel replication factor in both axes (0..2)
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- pix_en  in  1  pixel-rate strobe; all state advances only on clk edges with pix_en=1
- mode  in  2  00 grey, 01 RGB332, 10 colour bars, 11 black
- mem_addr  out  ADDR_W  frame-buffer read address
- mem_rd  out  1  read request, high only for visible pixels
- mem_data  in  8  read data, valid MEM_LAT pix_en-cycles after its mem_rd
- vga_hs, vga_vs  out  1  syncs, active-low
- vga_blank  out  1  active-low blank (1 = visible)
- r_out, g_out, b_out  out  8  colour
- frame_start  out  1  one-cycle pulse at h=0, v=0 (undelayed)

## Operation
- Counters:
  - h counts 0..H_TOTAL-1.
  - v increments when h wraps and counts 0..V_TOTAL-1.
  - TOTAL = ACTIVE+FP+SYNC+BP.
- Raw region signals:
  - visible = h<H_ACTIVE && v<V_ACTIVE
  - hs low for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
  - vs uses the same rule on v
- Address: mem_addr = line_base + (h>>SCALE_SH).
  - line_base resets to 0 at frame start.
  - At the h wrap of a visible line, line_base advances by H_ACTIVE>>SCALE_SH only when the low SCALE_SH bits of v are all 1.
  - mem_addr holds its last value when not visible.
- mem_rd = visible (combinational from registered counters).
- Alignment: visible, hs and vs pass through a MEM_LAT-stage shift register clocked on pix_en, then one output register stage.
  - Outputs, including data, are therefore registered at MEM_LAT+1 pix_en-cycles from the counter state.
- Colour, computed in the output stage from mem_data:
  - grey: r=g=b=d.
  - RGB332, bit replication:
    - r={d[7:5],d[7:5],d[7:6]}
    - g={d[4:2],d[4:2],d[4:3]}
    - b={d[1:0],d[1:0],d[1:0],d[1:0]}
  - colour bars: eight equal bands over H_ACTIVE, index = delayed h*8/H_ACTIVE; band k gives r/g/b = {8{k[2]}},{8{k[1]}},{8{k[0]}}. The delayed h copy rides the alignment pipe. No memory data is used.
  - black: all 0.
- RGB forced to 0 whenever the delayed visible flag is 0.
- mode is latched into mode_q on the frame_start cycle; mode_q resets to 00. Changes mid-frame take effect at the next frame.

## Timing
- Reset values (asynchronous, immediate):
  - h=v=0, line_base=0, pipe flushed
  - vga_hs=vga_vs=1
  - vga_blank=0
  - RGB=0, mem_rd=0
  - frame_start=0
- First pix_en after reset release: frame_start=1 and mem_rd=1 with addr 0.
- Default parameters: H_TOTAL=800, V_TOTAL=525, 420000 pix_en cycles per frame.
- pix_en=0: all registers hold. Outputs are stable for the entire low period.
- Reset mid-frame: immediate return to reset values; the in-flight pipe contents are discarded.

## Structure
- Shared package vga_pkg:
  - mode encodings (MODE_GREY, MODE_RGB332, MODE_BARS, MODE_BLACK)
  - default 640x480 timing constants
  - RGB332-expand function
- One sub-module, vga_timing_gen: h/v counters, raw hs/vs/visible, frame_start. The parent holds the address generator, alignment pipe and colour stage.

## Test plan
- Default parameters, pix_en=1, mode grey, memory model returns addr[7:0] with MEM_LAT=1 -> pixel (5,0) outputs 0x05 on all channels, 2 cycles after mem_addr=5; address at (639,479)=307199; blank low outside visible.
- Sync check -> vga_hs low exactly 96 cycles from h=656; vga_vs low on lines 490-491; frame_start period 420000 cycles.
- SCALE_SH=1 -> (x=3,y=3) gives mem_addr=321; lines 0 and 1 issue identical address sequences 0..319.
- mode RGB332 with data 0xE3 -> r=0xFF, g=0x00, b=0xFF; mode switched to black mid-frame -> takes effect only after the next frame_start.
- MEM_LAT=3 -> sync and blank edges shift by 4 cycles relative to the raw counters; data remains aligned to its pixel.
- pix_en high every 2nd clk, then reset asserted at v=100 -> output sequence identical but each value held 2 clks; on reset, outputs take reset values immediately and the next frame_start follows release.
